// File: rtl/pid_pkg.sv
// pid_pkg
//   Shared types and constants for the pid front end.
//   sm32_t     : 32-bit sign-magnitude value, sign in the MSB, magnitude in [30:0].
//   state_t    : sequencer states of pid_error_stage.
//   SM_MAG_MAX : largest representable magnitude, used as the saturation value.
//   sm_negate  : flips the sign of a sign-magnitude value.
package pid_pkg;

  typedef struct packed {
    logic        sign;
    logic [30:0] mag;
  } sm32_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    CALC,
    ISSUE,
    WAIT_DONE
  } state_t;

  localparam logic [30:0] SM_MAG_MAX = 31'h7FFF_FFFF;

  // Negation of a sign-magnitude value is a sign flip; a -0 result is
  // harmless because the subtractor normalises zero results.
  function automatic sm32_t sm_negate(input sm32_t x);
    sm32_t r;
    r.sign = ~x.sign;
    r.mag  = x.mag;
    return r;
  endfunction

endpackage

// File: rtl/sm_sub_sat.sv
// sm_sub_sat
//   Combinational sign-magnitude subtract: diff = a - b.
//   The magnitude saturates at SM_MAG_MAX and a zero result is always +0.
//   Ports:
//     a    in  32  minuend, sign-magnitude
//     b    in  32  subtrahend, sign-magnitude
//     diff out 32  saturated sign-magnitude difference
//     sat  out 1   high when the magnitude was clamped
module sm_sub_sat
  import pid_pkg::*;
(
  input  sm32_t a,
  input  sm32_t b,
  output sm32_t diff,
  output logic  sat
);

  sm32_t       nb;
  logic [31:0] mag_sum;
  logic        a_larger;

  // a - b is evaluated as a + (-b). Same signs add magnitudes, with the
  // carry out of bit 30 meaning overflow; opposite signs subtract the
  // smaller magnitude from the larger and keep the larger one's sign.
  // A -0 operand needs no special casing: its sign only matters when its
  // magnitude wins, which cannot happen for zero except in a zero result,
  // and zero results are forced to +0 at the end.
  always_comb begin
    nb       = sm_negate(b);
    mag_sum  = {1'b0, a.mag} + {1'b0, nb.mag};
    a_larger = (a.mag >= nb.mag);
    diff     = '0;
    sat      = 1'b0;
    if (a.sign == nb.sign) begin
      diff.sign = a.sign;
      if (mag_sum[31]) begin
        diff.mag = SM_MAG_MAX;
        sat      = 1'b1;
      end else begin
        diff.mag = mag_sum[30:0];
      end
    end else if (a_larger) begin
      diff.sign = a.sign;
      diff.mag  = a.mag - nb.mag;
    end else begin
      diff.sign = nb.sign;
      diff.mag  = nb.mag - a.mag;
    end
    if (diff.mag == '0) begin
      diff.sign = 1'b0;
    end
  end

endmodule

// File: rtl/pid_error_stage.sv
// pid_error_stage
//   Upstream sequencer for the pid block. Every PERIOD_CYCLES it latches the
//   sign-magnitude setpoint and position, computes the saturated error
//   setpoint - position and the measured sample interval, pulses start_calc
//   and waits (bounded by TIMEOUT_CYCLES) for the rising edge of done.
//   Ports:
//     clk          in   1   system clock
//     nrst         in   1   asynchronous active-low reset
//     en           in   1   sampling enable
//     clear_err    in   1   clears the sticky flags
//     setpoint     in   32  sign-magnitude setpoint
//     position     in   32  sign-magnitude measured position
//     done         in   1   pid completion, rising edge counts
//     start_calc   out  1   one-cycle start pulse to pid
//     error        out  32  sign-magnitude error to pid
//     delta_t      out  32  sample interval to pid
//     busy         out  1   sequencer not idle
//     err_sat      out  1   last computed error saturated
//     overrun_err  out  1   sticky: tick arrived while busy
//     timeout_err  out  1   sticky: done edge not seen in time
module pid_error_stage
  import pid_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int DT_SHIFT       = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic        clear_err,
  input  logic [31:0] setpoint,
  input  logic [31:0] position,
  input  logic        done,
  output logic        start_calc,
  output logic [31:0] error,
  output logic [31:0] delta_t,
  output logic        busy,
  output logic        err_sat,
  output logic        overrun_err,
  output logic        timeout_err
);

  localparam int             PCW          = $clog2(PERIOD_CYCLES);
  localparam logic [PCW-1:0] PERIOD_LAST  = PCW'(PERIOD_CYCLES - 1);
  localparam int             TCW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);
  localparam int             NOM_RAW      = PERIOD_CYCLES >> DT_SHIFT;
  localparam logic [31:0]    DT_NOMINAL   = (NOM_RAW == 0) ? 32'd1 : 32'(NOM_RAW);

  state_t         state;
  logic [PCW-1:0] period_cnt;
  logic           tick;
  logic [31:0]    elapsed;
  logic [TCW-1:0] wait_cnt;
  logic           done_q;
  logic           done_rise;
  logic           first_sample;
  sm32_t          sp_q;
  sm32_t          pos_q;
  sm32_t          error_q;
  sm32_t          err_calc;
  logic           sat_calc;
  logic [32:0]    interval;
  logic [31:0]    interval_sat;
  logic [31:0]    dt_shifted;
  logic [31:0]    dt_calc;

  assign tick      = (period_cnt == PERIOD_LAST);
  assign done_rise = done & ~done_q;
  assign busy      = (state != IDLE);
  assign error     = error_q;

  sm_sub_sat u_sub (
    .a    (sp_q),
    .b    (pos_q),
    .diff (err_calc),
    .sat  (sat_calc)
  );

  // Sample period timer; disabling sampling parks it at zero so the first
  // tick after re-enabling comes a full period later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      period_cnt <= '0;
    end else if (!en || tick) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PCW'(1);
    end
  end

  // Cycles since the last start pulse. It reads 0 in the cycle after ISSUE,
  // so in CALC the distance to the upcoming start pulse is elapsed + 2.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      elapsed <= '0;
    end else if (state == ISSUE) begin
      elapsed <= '0;
    end else if (elapsed != '1) begin
      elapsed <= elapsed + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Interval between start pulses, saturated, scaled and floored at 1.
  always_comb begin
    interval     = {1'b0, elapsed} + 33'd2;
    interval_sat = interval[32] ? '1 : interval[31:0];
    dt_shifted   = interval_sat >> DT_SHIFT;
    dt_calc      = DT_NOMINAL;
    if (!first_sample) begin
      dt_calc = (dt_shifted == '0) ? 32'd1 : dt_shifted;
    end
  end

  // Sequencer with registered outputs. A sticky set event is written after
  // the clear, so a set in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      sp_q         <= '0;
      pos_q        <= '0;
      error_q      <= '0;
      err_sat      <= 1'b0;
      delta_t      <= DT_NOMINAL;
      start_calc   <= 1'b0;
      wait_cnt     <= '0;
      first_sample <= 1'b1;
      overrun_err  <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start_calc <= 1'b0;
      if (clear_err) begin
        overrun_err <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tick && state != IDLE) begin
        overrun_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (tick && en) begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          sp_q  <= setpoint;
          pos_q <= position;
          state <= CALC;
        end
        CALC: begin
          error_q    <= err_calc;
          err_sat    <= sat_calc;
          delta_t    <= dt_calc;
          start_calc <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          wait_cnt     <= '0;
          first_sample <= 1'b0;
          state        <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_rise) begin
            state <= IDLE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + TCW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
